// File: rtl/stream_comp_packet_splitter.sv
// Packet splitter ahead of the stream-computation actor: one firing turns
// {command, L, L data} from the source FIFO into command/length/data FIFO writes.
// Optional macro PKT_COUNT_EN adds a 16-bit count of completed packets.
module stream_comp_packet_splitter #(
  parameter int width   = 10,
  parameter int max_len = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] src_data,
  input  logic             src_empty,
  output logic             rd_src,
  input  logic             invoke,
  input  logic             command_full,
  input  logic             length_full,
  input  logic             data_full,
  output logic [width-1:0] command_out,
  output logic [width-1:0] length_out,
  output logic [width-1:0] data_out,
  output logic             wr_command_fifo,
  output logic             wr_length_fifo,
  output logic             wr_data_fifo,
  output logic [1:0]       next_mode_out,
  output logic             FC,
  output logic             len_err
`ifdef PKT_COUNT_EN
  ,
  output logic [15:0]      pkt_count
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_REQ  = 3'd1,
    CMD_WR   = 3'd2,
    LEN_REQ  = 3'd3,
    LEN_WR   = 3'd4,
    DATA_REQ = 3'd5,
    DATA_WR  = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [width-1:0] MAX_LEN_W = width'(max_len);
  localparam logic [width-1:0] ONE_W     = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] ZERO_W    = {width{1'b0}};

  state_t           state_r;
  state_t           state_next_s;
  logic [width-1:0] remaining_r;
  logic [width-1:0] fwd_r;
  logic             len_err_r;
  logic [width-1:0] command_hold_r;
  logic [width-1:0] length_hold_r;
  logic [width-1:0] data_hold_r;

  logic             cmd_go_s;
  logic             len_go_s;
  logic             data_go_s;
  logic             len_over_s;
  logic [width-1:0] len_clip_s;

  // A token is only pulled from the source when its destination has room;
  // discarded overlength tokens need no destination slot.
  assign cmd_go_s   = !src_empty && !command_full;
  assign len_go_s   = !src_empty && !length_full;
  assign data_go_s  = !src_empty && ((fwd_r == ZERO_W) || !data_full);
  assign len_over_s = (src_data > MAX_LEN_W);
  assign len_clip_s = len_over_s ? MAX_LEN_W : src_data;

  assign next_mode_out = 2'b00;
  assign len_err       = len_err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (invoke) state_next_s = CMD_REQ;
        else        state_next_s = IDLE;
      end
      CMD_REQ: begin
        if (cmd_go_s) state_next_s = CMD_WR;
        else          state_next_s = CMD_REQ;
      end
      CMD_WR: state_next_s = LEN_REQ;
      LEN_REQ: begin
        if (len_go_s) state_next_s = LEN_WR;
        else          state_next_s = LEN_REQ;
      end
      LEN_WR: begin
        if (src_data == ZERO_W) state_next_s = DONE;
        else                    state_next_s = DATA_REQ;
      end
      DATA_REQ: begin
        if (data_go_s) state_next_s = DATA_WR;
        else           state_next_s = DATA_REQ;
      end
      DATA_WR: begin
        if (remaining_r == ONE_W) state_next_s = DONE;
        else                      state_next_s = DATA_REQ;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode: strobes from state, buses pass src_data only in their write state.
  always_comb begin
    rd_src          = 1'b0;
    wr_command_fifo = 1'b0;
    wr_length_fifo  = 1'b0;
    wr_data_fifo    = 1'b0;
    FC              = 1'b0;
    command_out     = command_hold_r;
    length_out      = length_hold_r;
    data_out        = data_hold_r;
    case (state_r)
      CMD_REQ:  rd_src = cmd_go_s;
      CMD_WR: begin
        wr_command_fifo = 1'b1;
        command_out     = src_data;
      end
      LEN_REQ:  rd_src = len_go_s;
      LEN_WR: begin
        wr_length_fifo = 1'b1;
        length_out     = len_clip_s;
      end
      DATA_REQ: rd_src = data_go_s;
      DATA_WR: begin
        if (fwd_r != ZERO_W) begin
          wr_data_fifo = 1'b1;
          data_out     = src_data;
        end else begin
          wr_data_fifo = 1'b0;
        end
      end
      DONE:     FC = 1'b1;
      default:  rd_src = 1'b0;
    endcase
  end

  // Payload counters, sticky length error and bus hold registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining_r    <= ZERO_W;
      fwd_r          <= ZERO_W;
      len_err_r      <= 1'b0;
      command_hold_r <= ZERO_W;
      length_hold_r  <= ZERO_W;
      data_hold_r    <= ZERO_W;
    end else begin
      case (state_r)
        CMD_WR: command_hold_r <= src_data;
        LEN_WR: begin
          length_hold_r <= len_clip_s;
          remaining_r   <= src_data;
          fwd_r         <= len_clip_s;
          if (len_over_s) len_err_r <= 1'b1;
        end
        DATA_WR: begin
          remaining_r <= remaining_r - ONE_W;
          if (fwd_r != ZERO_W) begin
            fwd_r       <= fwd_r - ONE_W;
            data_hold_r <= src_data;
          end
        end
        default: remaining_r <= remaining_r;
      endcase
    end
  end

`ifdef PKT_COUNT_EN
  logic [15:0] pkt_count_r;

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count_r <= 16'h0000;
    end else if (state_r == DONE) begin
      pkt_count_r <= pkt_count_r + 16'h0001;
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_stream_comp_packet_splitter.sv
// Directed bench for stream_comp_packet_splitter: a shared source FIFO model
// feeds either a max_len=64 instance or a max_len=2 instance (selected by sel).
module tb_stream_comp_packet_splitter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       invoke = 1'b0;
  logic       sel = 1'b0;
  logic       command_full = 1'b0;
  logic       length_full = 1'b0;
  logic       data_full = 1'b0;
  logic [9:0] src_data = 10'd0;
  logic       src_empty;

  logic       rd_a, rd_b, wc_a, wc_b, wl_a, wl_b, wd_a, wd_b, fc_a, fc_b, le_a, le_b;
  logic [9:0] co_a, co_b, lo_a, lo_b, do_a, do_b;
  logic [1:0] nm_a, nm_b;

  logic [9:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_count = 0;
  int         fc_count = 0;
  logic [9:0] cmd_q[$];
  logic [9:0] len_q[$];
  logic [9:0] dat_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wire       rd_m  = sel ? rd_b : rd_a;
  wire       wc_m  = sel ? wc_b : wc_a;
  wire       wl_m  = sel ? wl_b : wl_a;
  wire       wd_m  = sel ? wd_b : wd_a;
  wire       fc_m  = sel ? fc_b : fc_a;
  wire [9:0] co_m  = sel ? co_b : co_a;
  wire [9:0] lo_m  = sel ? lo_b : lo_a;
  wire [9:0] do_m  = sel ? do_b : do_a;
  assign src_empty = (rd_ptr == wr_ptr);

  stream_comp_packet_splitter #(.width(10), .max_len(64)) u_dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_empty(src_empty), .rd_src(rd_a),
    .invoke(invoke && !sel), .command_full(command_full), .length_full(length_full),
    .data_full(data_full), .command_out(co_a), .length_out(lo_a), .data_out(do_a),
    .wr_command_fifo(wc_a), .wr_length_fifo(wl_a), .wr_data_fifo(wd_a),
    .next_mode_out(nm_a), .FC(fc_a), .len_err(le_a));

  stream_comp_packet_splitter #(.width(10), .max_len(2)) u_dut_ovl (
    .clk(clk), .rst(rst), .src_data(src_data), .src_empty(src_empty), .rd_src(rd_b),
    .invoke(invoke && sel), .command_full(command_full), .length_full(length_full),
    .data_full(data_full), .command_out(co_b), .length_out(lo_b), .data_out(do_b),
    .wr_command_fifo(wc_b), .wr_length_fifo(wl_b), .wr_data_fifo(wd_b),
    .next_mode_out(nm_b), .FC(fc_b), .len_err(le_b));

  // Source FIFO model: read data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_m) begin
      rd_count <= rd_count + 1;
      if (rd_ptr != wr_ptr) begin
        src_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  // Destination FIFO capture
  always @(posedge clk) begin
    if (wc_m) cmd_q.push_back(co_m);
    if (wl_m) len_q.push_back(lo_m);
    if (wd_m) dat_q.push_back(do_m);
    if (fc_m) fc_count <= fc_count + 1;
  end

  task automatic push(input logic [9:0] v);
    @(negedge clk);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_sinks();
    @(negedge clk);
    cmd_q.delete();
    len_q.delete();
    dat_q.delete();
  endtask

  // Pulse invoke and count edges until FC (cyc = edges since invoke sampled, 1-based)
  task automatic fire(output int cyc);
    @(negedge clk);
    invoke = 1'b1;
    @(posedge clk); #1;
    invoke = 1'b0;
    cyc = 1;
    while (fc_m !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    invoke = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rd_a, wc_a, wl_a, wd_a, fc_a, le_a, rd_b, wc_b, wl_b, wd_b, fc_b, le_b} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0", {rd_a, wc_a, wl_a, wd_a, fc_a, le_a, rd_b, wc_b, wl_b, wd_b, fc_b, le_b});
    end
    n_cmp++;
    if ({co_a, lo_a, do_a, co_b, lo_b, do_b} !== 60'd0) begin
      n_err++;
      $display("FAIL reset_buses: got %h %h %h want 0", co_a, lo_a, do_a);
    end
    n_cmp++;
    if ({nm_a, nm_b} !== 4'b0000) begin
      n_err++;
      $display("FAIL next_mode: got %b want 0000", {nm_a, nm_b});
    end
    @(negedge clk);
    rst = 1'b1;
    invoke = 1'b0;
    push(10'd5);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rd_count !== 0) begin
      n_err++;
      $display("FAIL reset_no_start: rd_count %0d want 0", rd_count);
    end
  endtask

  task automatic test_basic();
    int cyc;
    push(10'd3); push(10'd10); push(10'd11); push(10'd12);
    clear_sinks();
    fire(cyc);
    n_cmp++;
    if (cyc + 1 !== 12) begin
      n_err++;
      $display("FAIL basic_latency: FC cycle %0d want 12", cyc + 1);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_q.size() !== 1 || cmd_q[0] !== 10'd5) begin
      n_err++;
      $display("FAIL basic_cmd: size %0d head %0d want 1/5", cmd_q.size(), cmd_q[0]);
    end
    n_cmp++;
    if (len_q.size() !== 1 || len_q[0] !== 10'd3) begin
      n_err++;
      $display("FAIL basic_len: size %0d head %0d want 1/3", len_q.size(), len_q[0]);
    end
    n_cmp++;
    if (dat_q.size() !== 3 || dat_q[0] !== 10'd10 || dat_q[1] !== 10'd11 || dat_q[2] !== 10'd12) begin
      n_err++;
      $display("FAIL basic_data: size %0d got %0d %0d %0d want 10 11 12", dat_q.size(), dat_q[0], dat_q[1], dat_q[2]);
    end
    n_cmp++;
    if (fc_count !== 1) begin
      n_err++;
      $display("FAIL basic_fc_once: fc_count %0d want 1", fc_count);
    end
    n_cmp++;
    if (do_a !== 10'd12 || co_a !== 10'd5 || lo_a !== 10'd3) begin
      n_err++;
      $display("FAIL basic_hold: got %0d %0d %0d want 5 3 12", co_a, lo_a, do_a);
    end
  endtask

  task automatic test_zero_length();
    int cyc;
    int fc0;
    fc0 = fc_count;
    push(10'd7); push(10'd0);
    clear_sinks();
    fire(cyc);
    n_cmp++;
    if (cyc + 1 !== 6) begin
      n_err++;
      $display("FAIL zero_latency: FC cycle %0d want 6", cyc + 1);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_q.size() !== 1 || cmd_q[0] !== 10'd7 || len_q.size() !== 1 || len_q[0] !== 10'd0) begin
      n_err++;
      $display("FAIL zero_cmd_len: got %0d/%0d want 7/0", cmd_q[0], len_q[0]);
    end
    n_cmp++;
    if (dat_q.size() !== 0 || fc_count - fc0 !== 1) begin
      n_err++;
      $display("FAIL zero_no_data: data writes %0d fc %0d want 0/1", dat_q.size(), fc_count - fc0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int rd0;
    int cyc;
    push(10'd1); push(10'd2); push(10'd4); push(10'd9);
    clear_sinks();
    @(negedge clk);
    invoke = 1'b1;
    @(posedge clk); #1;
    invoke = 1'b0;
    n = 0;
    while (wl_m !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    @(negedge clk);
    data_full = 1'b1;
    rd0 = rd_count;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (rd_count !== rd0 || dat_q.size() !== 0) begin
      n_err++;
      $display("FAIL bp_stall: reads %0d writes %0d while full, want 0/0", rd_count - rd0, dat_q.size());
    end
    @(negedge clk);
    data_full = 1'b0;
    cyc = 0;
    while (fc_m !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
    end
    n_cmp++;
    if (fc_m !== 1'b1) begin
      n_err++;
      $display("FAIL bp_fc: FC %b want 1", fc_m);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dat_q.size() !== 2 || dat_q[0] !== 10'd4 || dat_q[1] !== 10'd9 || cmd_q[0] !== 10'd1 || len_q[0] !== 10'd2) begin
      n_err++;
      $display("FAIL bp_data: size %0d got %0d %0d want 4 9", dat_q.size(), dat_q[0], dat_q[1]);
    end
    n_cmp++;
    if (rd_ptr !== wr_ptr) begin
      n_err++;
      $display("FAIL bp_consumed: rd_ptr %0d want %0d", rd_ptr, wr_ptr);
    end
  endtask

  task automatic test_overlength();
    int cyc;
    @(negedge clk);
    sel = 1'b1;
    push(10'd3); push(10'd4); push(10'd20); push(10'd21); push(10'd22); push(10'd23);
    clear_sinks();
    fire(cyc);
    n_cmp++;
    if (cyc + 1 !== 14) begin
      n_err++;
      $display("FAIL ovl_latency: FC cycle %0d want 14", cyc + 1);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (len_q.size() !== 1 || len_q[0] !== 10'd2 || cmd_q[0] !== 10'd3) begin
      n_err++;
      $display("FAIL ovl_len: got %0d want 2", len_q[0]);
    end
    n_cmp++;
    if (dat_q.size() !== 2 || dat_q[0] !== 10'd20 || dat_q[1] !== 10'd21) begin
      n_err++;
      $display("FAIL ovl_data: size %0d got %0d %0d want 20 21", dat_q.size(), dat_q[0], dat_q[1]);
    end
    n_cmp++;
    if (rd_ptr !== wr_ptr) begin
      n_err++;
      $display("FAIL ovl_discard: rd_ptr %0d want %0d", rd_ptr, wr_ptr);
    end
    n_cmp++;
    if (le_b !== 1'b1 || le_a !== 1'b0) begin
      n_err++;
      $display("FAIL ovl_len_err: got %b/%b want 1/0", le_b, le_a);
    end
    push(10'd8); push(10'd1); push(10'd30);
    clear_sinks();
    fire(cyc);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (le_b !== 1'b1 || dat_q.size() !== 1 || dat_q[0] !== 10'd30) begin
      n_err++;
      $display("FAIL ovl_sticky: len_err %b data %0d want 1/30", le_b, dat_q[0]);
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_payload();
    int n;
    int cyc;
    push(10'd6); push(10'd3); push(10'd40); push(10'd9); push(10'd0);
    clear_sinks();
    @(negedge clk);
    invoke = 1'b1;
    @(posedge clk); #1;
    invoke = 1'b0;
    n = 0;
    while (wd_m !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({rd_a, wc_a, wl_a, wd_a, fc_a} !== 5'b00000) begin
      n_err++;
      $display("FAIL mid_reset_idle: strobes %b want 00000", {rd_a, wc_a, wl_a, wd_a, fc_a});
    end
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if (dat_q.size() !== 1 || dat_q[0] !== 10'd40) begin
      n_err++;
      $display("FAIL mid_reset_kept: size %0d head %0d want 1/40", dat_q.size(), dat_q[0]);
    end
    clear_sinks();
    fire(cyc);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cyc + 1 !== 6 || cmd_q[0] !== 10'd9 || len_q[0] !== 10'd0 || dat_q.size() !== 0) begin
      n_err++;
      $display("FAIL mid_reset_reparse: cycle %0d cmd %0d len %0d want 6/9/0", cyc + 1, cmd_q[0], len_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_backpressure();
    test_overlength();
    test_reset_mid_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_comp_packet_splitter.md
Name: stream_comp_packet_splitter

Overview:
- Upstream stage of the stream-computation actor. It consumes one packet per firing from a single source FIFO and demultiplexes it into the command, length and data FIFOs that the actor reads.
- A packet is one command token, one length token L, then L data tokens.
- Uses the standard CFDF invoke/FC handshake, so the same scheduler that invokes the stream-computation actor can schedule it.

Parameters:
- width, 10, bit width of every token and data bus.
- max_len, 64, largest payload forwarded per packet; must fit in width bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- src_data  in  width  source FIFO read data; valid the cycle after rd_src
- src_empty  in  1  source FIFO empty flag
- rd_src  out  1  source FIFO read enable
- invoke  in  1  start one firing (one packet)
- command_full  in  1  command FIFO full
- length_full  in  1  length FIFO full
- data_full  in  1  data FIFO full
- command_out  out  width  command FIFO write data
- length_out  out  width  length FIFO write data
- data_out  out  width  data FIFO write data
- wr_command_fifo  out  1  command FIFO write enable
- wr_length_fifo  out  1  length FIFO write enable
- wr_data_fifo  out  1  data FIFO write enable
- next_mode_out  out  2  CFDF next mode; constant 2'b00 (single mode)
- FC  out  1  firing complete, 1-cycle pulse
- len_err  out  1  sticky flag: a packet with L > max_len was seen

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all strobes, FC and len_err = 0; remaining counter = 0; command_out, length_out and data_out = 0.
- Reset mid-firing aborts immediately. Tokens already written stay in the destination FIFOs; nothing is rolled back.
- States and transitions:
  - IDLE: on invoke -> CMD_REQ. Invoke in any other state is ignored.
  - CMD_REQ: if !src_empty && !command_full, assert rd_src -> CMD_WR; otherwise stall.
  - CMD_WR: wr_command_fifo=1, command_out=src_data -> LEN_REQ.
  - LEN_REQ: if !src_empty && !length_full, assert rd_src -> LEN_WR.
  - LEN_WR: wr_length_fifo=1.
    - length_out = min(src_data, max_len).
    - remaining = src_data; fwd = min(src_data, max_len).
    - If src_data > max_len, set len_err.
    - If src_data == 0 -> DONE; else -> DATA_REQ.
  - DATA_REQ:
    - Forwarding token (fwd > 0): requires !src_empty && !data_full.
    - Discard token (fwd == 0, remaining > 0): requires only !src_empty.
    - When the condition holds, assert rd_src -> DATA_WR.
  - DATA_WR:
    - If fwd > 0: wr_data_fifo=1, data_out=src_data, fwd--.
    - remaining-- in all cases.
    - If remaining was 1 -> DONE; else -> DATA_REQ.
  - DONE: FC=1 for exactly one cycle -> IDLE.
- Write strobes are single-cycle. Data buses follow src_data combinationally in their write state and hold their last value otherwise.
- Full flags are sampled only in the REQ states. This block is the sole writer of its destination FIFOs, so a token is never read from the source without a guaranteed slot.
- Throughput: 2 cycles per token with no stalls. Firing latency from invoke to FC = 2·(2+L)+2 cycles.
- len_err is cleared only by reset.
- Arithmetic is unsigned. The counters are width bits and never wrap, because they are decremented only while nonzero.

Optional Feature:
- Macro PKT_COUNT_EN.
- Defined: adds output pkt_count (16 bits). Resets to 0 and increments in DONE, wrapping from 16'hFFFF to 0.
- Undefined: no port and no counter logic.

Test Plan:
- Reset check: rst=0 for 2 cycles -> all strobes, FC and len_err = 0; invoke during reset does not start a firing.
- Basic packet: source holds {5, 3, 10, 11, 12}, invoke -> command FIFO gets 5, length FIFO gets 3, data FIFO gets 10,11,12; FC pulses once at cycle 12 after invoke.
- Zero-length packet: source holds {7, 0} -> command 7, length 0, no wr_data_fifo; FC at cycle 6.
- Backpressure: data_full=1 for 5 cycles during payload of {1, 2, 4, 9} -> no rd_src while stalled, data FIFO gets 4,9 in order, no tokens lost or duplicated.
- Overlength packet: max_len=2, source holds {3, 4, 20, 21, 22, 23} -> length FIFO gets 2, data FIFO gets 20,21, tokens 22 and 23 are consumed and discarded; len_err=1 and stays set.
- Reset mid-payload: rst=0 after 1 data token -> next cycle IDLE with all strobes 0; a new invoke then parses from the current source head.
